// File: rtl/key_gen_pkg.sv
// Shared types and sizing helpers for the key-press generator.
package key_gen_pkg;

    typedef enum logic [1:0] {IDLE, PRESS, GAP} key_gen_state_t;

    function automatic int timer_width(int press_cycles, int gap_cycles);
        int m;
        m = (press_cycles > gap_cycles) ? press_cycles : gap_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; parks at zero until reloaded.
module cycle_timer #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset)
            r_cnt <= '0;
        else if (load)
            r_cnt <= load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/key_press_gen.sv
// Turns one-cycle request pulses into active-low press/release waveforms,
// queueing requests that arrive while a press is in progress.
module key_press_gen
    import key_gen_pkg::*;
#(
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int QUEUE_DEPTH  = 7
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               req,
    output logic                               key,
    output logic                               busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending,
    output logic                               dropped
);

    localparam int TW = timer_width(PRESS_CYCLES, GAP_CYCLES);
    localparam int PW = $clog2(QUEUE_DEPTH + 1);

    key_gen_state_t r_state;

    logic          w_zero;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic          w_have_pend;
    logic          w_start_req;
    logic          w_start_pend;
    logic          w_gap_next;
    logic          w_press_end;
    logic          w_enq;
    logic          w_deq;
    logic          w_full;

    assign w_have_pend  = (pending != '0);
    assign w_start_req  = (r_state == IDLE) && req;
    assign w_start_pend = (r_state == IDLE) && !req && w_have_pend;
    assign w_press_end  = (r_state == PRESS) && w_zero;
    assign w_gap_next   = (r_state == GAP) && w_zero && w_have_pend;

    // A request is queued unless it directly starts a press from IDLE.
    assign w_enq  = req && !w_start_req;
    assign w_deq  = w_start_pend || w_gap_next;
    assign w_full = (pending == PW'(QUEUE_DEPTH));

    assign w_load     = w_start_req || w_start_pend || w_press_end || w_gap_next;
    assign w_load_val = w_press_end ? TW'(GAP_CYCLES - 1) : TW'(PRESS_CYCLES - 1);

    cycle_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            key     <= 1'b1;
            busy    <= 1'b0;
            pending <= '0;
            dropped <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_req || w_start_pend) begin
                        r_state <= PRESS;
                        key     <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                PRESS: begin
                    if (w_zero) begin
                        r_state <= GAP;
                        key     <= 1'b1;
                    end
                end
                GAP: begin
                    if (w_gap_next) begin
                        r_state <= PRESS;
                        key     <= 1'b0;
                    end else if (w_zero) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    key     <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase

            dropped <= 1'b0;
            if (w_enq && !w_deq) begin
                if (w_full)
                    dropped <= 1'b1;
                else
                    pending <= pending + 1'b1;
            end else if (w_deq && !w_enq) begin
                pending <= pending - 1'b1;
            end
        end
    end

endmodule
